prng_sequencer: RTL and testbench

Single-clock controller that sequences the PRNG datapath: the 16-bit data LFSR, the 8-bit control LFSR and the 16-to-8 mux. It replaces derived/ripple clocks with one-cycle step enables and seeds both LFSRs away from the XNOR lock-up state. It supports run, pause and single-step modes, and captures the mux output into a held display byte for the two 7-segment decoders.

---
 rtl/prng_sequencer.sv | 162 ++++++++++++++++
 tb/tb_prng_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prng_sequencer.sv
// Single-clock sequencer for the PRNG datapath: step enables, seeding,
// run/pause/single-step control and display-byte capture.
module prng_sequencer #(
    parameter int unsigned DATA_DIV = 10_000_000,
    parameter int unsigned CTRL_DIV = 4,
    parameter int unsigned CNT_W    = 24,
    parameter logic [15:0] SEED_D   = 16'hACE1,
    parameter logic [7:0]  SEED_C   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        run,
    input  logic        step,
    input  logic        reseed,
    input  logic [7:0]  seed_in,
    input  logic [7:0]  sample_i,
    output logic        data_step_o,
    output logic        ctrl_step_o,
    output logic        load_o,
    output logic [15:0] load_data_o,
    output logic [7:0]  load_ctrl_o,
    output logic [7:0]  disp_o,
    output logic        disp_valid_o,
    output logic        tick_o,
    output logic [1:0]  state_o
);

    localparam int unsigned CW = $clog2(CTRL_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEED  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_presc, w_presc;
    logic [CW-1:0]    r_ccnt,  w_ccnt;
    logic             r_dstep, w_dstep;
    logic             r_cstep, w_cstep;
    logic             r_load,  w_load;
    logic [15:0]      r_ld_d,  w_ld_d;
    logic [7:0]       r_ld_c,  w_ld_c;
    logic [7:0]       r_disp,  w_disp;
    logic             r_dvld,  w_dvld;
    logic             r_tick,  w_tick;
    logic             w_adv;
    logic [15:0]      w_seed_d;
    logic [7:0]       w_seed_c;

    // All-ones is the XNOR LFSR lock-up state; fall back to the base seed.
    always_comb begin
        w_seed_d = SEED_D ^ {seed_in, seed_in};
        w_seed_c = SEED_C ^ seed_in;
        if (w_seed_d == 16'hFFFF) w_seed_d = SEED_D;
        if (w_seed_c == 8'hFF)    w_seed_c = SEED_C;
    end

    always_comb begin
        w_state = r_state;
        w_presc = r_presc;
        w_ccnt  = r_ccnt;
        w_dstep = 1'b0;
        w_cstep = 1'b0;
        w_load  = 1'b0;
        w_ld_d  = r_ld_d;
        w_ld_c  = r_ld_c;
        w_disp  = r_disp;
        w_dvld  = 1'b0;
        w_tick  = r_tick;
        w_adv   = 1'b0;
        if (!ena) begin
            w_state = S_IDLE;
            w_presc = '0;
            w_ccnt  = '0;
            w_disp  = '0;
            w_tick  = 1'b0;
        end else begin
            // Capture one cycle after a step so the LFSRs and mux have settled.
            if (r_dstep) begin
                w_disp = sample_i;
                w_dvld = 1'b1;
            end
            case (r_state)
                S_IDLE: w_state = S_SEED;
                S_SEED: begin
                    w_load  = 1'b1;
                    w_ld_d  = w_seed_d;
                    w_ld_c  = w_seed_c;
                    w_presc = '0;
                    w_ccnt  = '0;
                    w_state = run ? S_RUN : S_PAUSE;
                end
                S_RUN: begin
                    if (reseed)       w_state = S_SEED;
                    else if (!run)    w_state = S_PAUSE;
                    else if (r_presc == CNT_W'(DATA_DIV - 1)) begin
                        w_presc = '0;
                        w_adv   = 1'b1;
                    end else          w_presc = r_presc + CNT_W'(1);
                end
                S_PAUSE: begin
                    if (reseed)       w_state = S_SEED;
                    else if (run)     w_state = S_RUN;
                    else if (step)    w_adv   = 1'b1;
                end
                default: w_state = S_IDLE;
            endcase
            if (w_adv) begin
                w_dstep = 1'b1;
                w_tick  = ~r_tick;
                if (r_ccnt == CW'(CTRL_DIV - 1)) begin
                    w_ccnt  = '0;
                    w_cstep = 1'b1;
                end else begin
                    w_ccnt  = r_ccnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_ccnt  <= '0;
            r_dstep <= 1'b0;
            r_cstep <= 1'b0;
            r_load  <= 1'b0;
            r_ld_d  <= '0;
            r_ld_c  <= '0;
            r_disp  <= '0;
            r_dvld  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_presc <= w_presc;
            r_ccnt  <= w_ccnt;
            r_dstep <= w_dstep;
            r_cstep <= w_cstep;
            r_load  <= w_load;
            r_ld_d  <= w_ld_d;
            r_ld_c  <= w_ld_c;
            r_disp  <= w_disp;
            r_dvld  <= w_dvld;
            r_tick  <= w_tick;
        end
    end

    assign data_step_o  = r_dstep;
    assign ctrl_step_o  = r_cstep;
    assign load_o       = r_load;
    assign load_data_o  = r_ld_d;
    assign load_ctrl_o  = r_ld_c;
    assign disp_o       = r_disp;
    assign disp_valid_o = r_dvld;
    assign tick_o       = r_tick;
    assign state_o      = r_state;

endmodule

// File: tb/tb_prng_sequencer.sv
// Randomized bench for prng_sequencer against an event-counting reference model.
module tb_prng_sequencer;

    localparam int DDIV = 4;
    localparam int CDIV = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, run = 1'b0, step = 1'b0, reseed = 1'b0;
    logic [7:0]  seed_in = 8'h00, sample_i = 8'h00;
    logic        data_step_o, ctrl_step_o, load_o, disp_valid_o, tick_o;
    logic [15:0] load_data_o;
    logic [7:0]  load_ctrl_o, disp_o;
    logic [1:0]  state_o;

    prng_sequencer #(.DATA_DIV(DDIV), .CTRL_DIV(CDIV), .CNT_W(8),
                     .SEED_D(16'hACE1), .SEED_C(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step),
        .reseed(reseed), .seed_in(seed_in), .sample_i(sample_i),
        .data_step_o(data_step_o), .ctrl_step_o(ctrl_step_o), .load_o(load_o),
        .load_data_o(load_data_o), .load_ctrl_o(load_ctrl_o), .disp_o(disp_o),
        .disp_valid_o(disp_valid_o), .tick_o(tick_o), .state_o(state_o));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: prescaler position is the count of RUN advances since
    // seeding; control steps fall on every CDIV-th data step since seeding.
    int          m_st, m_runs, m_steps, m_total;
    logic        e_dstep, e_cstep, e_load, e_dvld;
    logic [15:0] e_ldd;
    logic [7:0]  e_ldc, e_disp;

    function automatic logic [15:0] seed_d(input logic [7:0] s);
        logic [15:0] v;
        v = 16'hACE1 ^ {s, s};
        return (v == 16'hFFFF) ? 16'hACE1 : v;
    endfunction

    function automatic logic [7:0] seed_c(input logic [7:0] s);
        logic [7:0] v;
        v = 8'h5A ^ s;
        return (v == 8'hFF) ? 8'h5A : v;
    endfunction

    task automatic mdl_reset();
        m_st = 0; m_runs = 0; m_steps = 0; m_total = 0;
        e_dstep = 0; e_cstep = 0; e_load = 0; e_dvld = 0;
        e_ldd = 0; e_ldc = 0; e_disp = 0;
    endtask

    task automatic mdl();
        bit fire, pend;
        if (!rst_n) begin mdl_reset(); return; end
        pend = e_dstep; fire = 0;
        e_dstep = 0; e_cstep = 0; e_load = 0; e_dvld = 0;
        if (!ena) begin
            m_st = 0; m_runs = 0; m_steps = 0; m_total = 0; e_disp = 0;
            return;
        end
        if (pend) begin e_disp = sample_i; e_dvld = 1; end
        case (m_st)
            0: m_st = 1;
            1: begin
                e_load = 1; e_ldd = seed_d(seed_in); e_ldc = seed_c(seed_in);
                m_runs = 0; m_steps = 0; m_st = run ? 2 : 3;
            end
            2: if (reseed) m_st = 1;
               else if (!run) m_st = 3;
               else begin m_runs++; fire = (m_runs % DDIV) == 0; end
            default: if (reseed) m_st = 1;
               else if (run) m_st = 2;
               else fire = step;
        endcase
        if (fire) begin
            m_steps++; m_total++;
            e_dstep = 1;
            e_cstep = (m_steps % CDIV) == 0;
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_st));
        chk("data_step", 32'(data_step_o), 32'(e_dstep));
        chk("ctrl_step", 32'(ctrl_step_o), 32'(e_cstep));
        chk("load", 32'(load_o), 32'(e_load));
        chk("load_data", 32'(load_data_o), 32'(e_ldd));
        chk("load_ctrl", 32'(load_ctrl_o), 32'(e_ldc));
        chk("disp", 32'(disp_o), 32'(e_disp));
        chk("disp_valid", 32'(disp_valid_o), 32'(e_dvld));
        chk("tick", 32'(tick_o), 32'(m_total % 2));
        chk("load_step_excl", 32'(load_o & data_step_o), 32'd0);
    endtask

    // One clock: model follows the DUT edge, compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        mdl();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_dstep(input string tag, input int budget);
        int k;
        for (k = 0; k < budget && !data_step_o; k++) cyc();
        if (!data_step_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int nd, nc, k, lat;
        logic t0;
        mdl_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("idle_hold", 32'(state_o), 32'd0);

        // Power-up seeding with seed_in = 0 and free-run.
        run = 1; ena = 1;
        for (k = 0; k < 6 && !load_o; k++) cyc();
        chk("seed_load", 32'(load_o), 32'd1);
        chk("seed_ldd", 32'(load_data_o), 32'hACE1);
        chk("seed_ldc", 32'(load_ctrl_o), 32'h5A);
        nd = 0; nc = 0; t0 = tick_o;
        for (k = 0; k < 6 * DDIV; k++) begin
            cyc();
            nd += int'(data_step_o); nc += int'(ctrl_step_o);
        end
        chk("run_steps", 32'(nd), 32'd6);
        chk("run_ctrl", 32'(nc), 32'd2);
        chk("tick_even", 32'(tick_o), 32'(t0));

        // Display capture one cycle after a step, then held.
        sample_i = 8'h3C;
        wait_dstep("s3c", 10);
        cyc();
        sample_i = 8'h99;
        chk("disp_3c", 32'(disp_o), 32'h3C);
        chk("disp_vld", 32'(disp_valid_o), 32'd1);
        cyc();
        chk("disp_hold", 32'(disp_o), 32'h3C);

        // Pause at prescaler 2, three manual steps, then resume.
        wait_dstep("pz", 10);
        cyc(); cyc();
        run = 0;
        cyc();
        nd = 0;
        for (k = 0; k < 3; k++) begin
            step = 1; cyc(); step = 0;
            nd += int'(data_step_o);
            cyc(); nd += int'(data_step_o);
        end
        cyc(); nd += int'(data_step_o);
        chk("pause_steps", 32'(nd), 32'd3);
        run = 1;
        cyc();
        chk("resume_state", 32'(state_o), 32'd2);
        lat = 0;
        for (k = 0; k < 8 && !data_step_o; k++) begin cyc(); lat++; end
        chk("resume_lat", 32'(lat), 32'd2);

        // Lock-up avoidance on the control seed.
        seed_in = 8'hA5; reseed = 1; cyc(); reseed = 0;
        cyc();
        chk("a5_load", 32'(load_o), 32'd1);
        chk("a5_ldc", 32'(load_ctrl_o), 32'h5A);
        chk("a5_ldd", 32'(load_data_o), 32'h0944);

        // Reseed on the terminal-count cycle wins over the step.
        wait_dstep("tc", 10);
        cyc(); cyc(); cyc();
        reseed = 1; cyc(); reseed = 0;
        chk("tc_nostep", 32'(data_step_o), 32'd0);
        cyc();
        chk("tc_load", 32'(load_o), 32'd1);

        // Disable during RUN, re-seed into PAUSE, async reset mid-PAUSE.
        for (k = 0; k < 5; k++) cyc();
        ena = 0; cyc(); cyc();
        chk("dis_state", 32'(state_o), 32'd0);
        chk("dis_tick", 32'(tick_o), 32'd0);
        run = 0; ena = 1;
        for (k = 0; k < 4; k++) cyc();
        step = 1; cyc(); step = 0; cyc();
        #2 rst_n = 0; ena = 0;
        #1;
        mdl_reset();
        check_all();
        cyc();
        rst_n = 1;
        for (k = 0; k < 4; k++) cyc();
        chk("rst_quiet", 32'(state_o), 32'd0);
        ena = 1; run = 1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            ena      = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 6) run = ~run;
            step     = ($urandom_range(0, 99) < 25);
            reseed   = ($urandom_range(0, 99) < 3);
            seed_in  = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
            sample_i = 8'($urandom);
            cyc();
        end
        step = 0; reseed = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
